// File: rtl/wu_mem_responder.sv
// WU instruction storage with a fixed 2-cycle read pipeline feeding a show-ahead skid FIFO.
// Back-pressure to the fetcher is registered and leaves room for requests already in flight.
module wu_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  wuf__wum__read,
  input  logic [ADDR_WIDTH-1:0] wuf__wum__addr,
  output logic                  wum__wuf__stall,
  input  logic                  mcntl__wum__write,
  input  logic [ADDR_WIDTH-1:0] mcntl__wum__addr,
  input  logic [DATA_WIDTH-1:0] mcntl__wum__data,
  output logic                  wum__wud__valid,
  output logic [DATA_WIDTH-1:0] wum__wud__data,
  input  logic                  wud__wum__stall,
  output logic                  wum__sys__overflow
);
  localparam int PTR_W     = $clog2(SKID_DEPTH);
  localparam int OCC_W     = PTR_W + 1;
  localparam int LVL_W     = OCC_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem  [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo [SKID_DEPTH];
  logic                  r_req_v0;
  logic                  r_req_v1;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_stall;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_accept;
  logic [OCC_W-1:0]      w_occ_next;
  logic [LVL_W-1:0]      w_level;

  always_ff @(posedge clk) begin
    if (mcntl__wum__write) r_mem[mcntl__wum__addr] <= mcntl__wum__data;
  end

  // The array is read on the sampling edge, so a write on that same edge is not observed.
  always_ff @(posedge clk) begin
    r_data0 <= r_mem[wuf__wum__addr];
    r_data1 <= r_data0;
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_req_v0 <= 1'b0;
      r_req_v1 <= 1'b0;
    end else begin
      r_req_v0 <= wuf__wum__read;
      r_req_v1 <= r_req_v0;
    end
  end

  assign w_full     = (r_occ == OCC_W'(SKID_DEPTH));
  assign w_pop      = (r_occ != '0) && !wud__wum__stall;
  assign w_push     = r_req_v1;
  assign w_accept   = w_push && (!w_full || w_pop);
  assign w_occ_next = r_occ + OCC_W'(w_accept) - OCC_W'(w_pop);
  // Projected fill: stored words plus everything the pipeline will deliver.
  assign w_level    = LVL_W'(w_occ_next) + LVL_W'(wuf__wum__read) + LVL_W'(r_req_v0);

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_occ_next;
      r_stall <= (w_level >= LVL_W'(SKID_DEPTH - 2));
      if (w_push && !w_accept) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_fifo[r_wr_ptr] <= r_data1;
  end

  assign wum__wuf__stall    = r_stall;
  assign wum__wud__valid    = (r_occ != '0);
  assign wum__wud__data     = wum__wud__valid ? r_fifo[r_rd_ptr] : '0;
  assign wum__sys__overflow = r_overflow;
endmodule

// File: tb/tb_wu_mem_responder.sv
// Directed bench for wu_mem_responder: latency, streaming, flow control, overflow,
// read-during-write ordering and reset in flight.
module tb_wu_mem_responder;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic          rd;
  logic [AW-1:0] ra;
  logic          st_f;
  logic          mw;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;
  logic          vld;
  logic [DW-1:0] dat;
  logic          dst;
  logic          ovf;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] exp_top;

  wu_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKID_DEPTH(SD)) dut (
    .clk                (clk),
    .reset_poweron      (reset_poweron),
    .wuf__wum__read     (rd),
    .wuf__wum__addr     (ra),
    .wum__wuf__stall    (st_f),
    .mcntl__wum__write  (mw),
    .mcntl__wum__addr   (ma),
    .mcntl__wum__data   (md),
    .wum__wud__valid    (vld),
    .wum__wud__data     (dat),
    .wud__wum__stall    (dst),
    .wum__sys__overflow (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mw = 1'b1; ma = a; md = d;
    @(negedge clk);
    mw = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int next, got, cyc;
    logic prev_st, saw_st;

    reset_poweron = 1'b1; rd = 1'b0; ra = '0; mw = 1'b0; ma = '0; md = '0; dst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset valid", 64'(vld), 64'd0);
    check("reset data", dat, 64'd0);
    check("reset stall", 64'(st_f), 64'd0);
    check("reset overflow", 64'(ovf), 64'd0);
    reset_poweron = 1'b0;

    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101;
      write_word(AW'(i), exp_mem[i]);
    end
    exp_top = 64'hFEED_0000_0000_03FF;
    write_word(AW'(1023), exp_top);

    // 1: single read, two cycles of latency, one-cycle valid
    exp_mem[5] = 64'hA5;
    write_word(AW'(5), exp_mem[5]);
    rd = 1'b1; ra = AW'(5);
    @(negedge clk); rd = 1'b0;
    check("t1 valid e1", 64'(vld), 64'd0);
    @(negedge clk);
    check("t1 valid e2", 64'(vld), 64'd0);
    @(negedge clk);
    check("t1 valid e3", 64'(vld), 64'd1);
    check("t1 data", dat, 64'hA5);
    @(negedge clk);
    check("t1 valid e4", 64'(vld), 64'd0);

    // 2: eight back-to-back reads stream out without gaps
    for (int c = 0; c < 12; c++) begin
      rd = (c < 8); ra = AW'(c);
      @(negedge clk);
      check("t2 valid", 64'(vld), (c >= 2 && c <= 9) ? 64'd1 : 64'd0);
      if (c >= 2 && c <= 9) check("t2 data", dat, exp_mem[c-2]);
    end
    rd = 1'b0;

    // 3: decoder stalled, fetcher obeys stall one cycle late
    next = 0; got = 0; cyc = 0; prev_st = 1'b0; saw_st = 1'b0;
    while (got < 16 && cyc < 300) begin
      dst = (cyc < 20);
      if (cyc == 19) check("t3 valid while stalled", 64'(vld), 64'd1);
      if (vld && !dst) begin
        check("t3 data", dat, exp_mem[got]);
        got++;
      end
      if (st_f) saw_st = 1'b1;
      rd = (next < 16) && !prev_st;
      ra = AW'(next);
      if (rd) next++;
      prev_st = st_f;
      @(negedge clk);
      cyc++;
    end
    rd = 1'b0; dst = 1'b0;
    check("t3 word count", 64'(got), 64'd16);
    check("t3 stall seen", 64'(saw_st), 64'd1);
    check("t3 overflow", 64'(ovf), 64'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("t3 drained", 64'(vld), 64'd0);

    // 5: same-edge write returns old data, next read returns new data
    write_word(AW'(3), 64'h22);
    mw = 1'b1; ma = AW'(3); md = 64'h11; rd = 1'b1; ra = AW'(3);
    @(negedge clk);
    mw = 1'b0;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    check("t5 valid old", 64'(vld), 64'd1);
    check("t5 old data", dat, 64'h22);
    @(negedge clk);
    check("t5 valid new", 64'(vld), 64'd1);
    check("t5 new data", dat, 64'h11);
    exp_mem[3] = 64'h11;
    @(negedge clk);

    // 4: fetcher ignores stall into a stalled decoder -> overflow, first four kept
    dst = 1'b1;
    for (int c = 0; c < 11; c++) begin
      rd = (c < 8); ra = AW'(8 + c);
      @(negedge clk);
    end
    rd = 1'b0;
    check("t4 overflow set", 64'(ovf), 64'd1);
    check("t4 stall", 64'(st_f), 64'd1);
    dst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4 valid", 64'(vld), 64'd1);
      check("t4 data", dat, exp_mem[8+i]);
      @(negedge clk);
    end
    check("t4 empty", 64'(vld), 64'd0);
    check("t4 overflow sticky", 64'(ovf), 64'd1);

    // 6: top address, reset with reads in flight, then post-reset read
    rd = 1'b1; ra = AW'(1023);
    @(negedge clk);
    ra = AW'(0); reset_poweron = 1'b1;
    @(negedge clk);
    reset_poweron = 1'b0; rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t6 valid after reset", 64'(vld), 64'd0);
      check("t6 stall after reset", 64'(st_f), 64'd0);
      @(negedge clk);
    end
    check("t6 overflow cleared", 64'(ovf), 64'd0);
    rd = 1'b1; ra = AW'(1023);
    @(negedge clk);
    ra = AW'(0);
    @(negedge clk);
    rd = 1'b0;
    check("t6 post valid e2", 64'(vld), 64'd0);
    @(negedge clk);
    check("t6 top valid", 64'(vld), 64'd1);
    check("t6 top data", dat, exp_top);
    @(negedge clk);
    check("t6 wrap valid", 64'(vld), 64'd1);
    check("t6 wrap data", dat, exp_mem[0]);
    @(negedge clk);
    check("t6 final empty", 64'(vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
